// File: rtl/aqed_fc_pkg.sv
// -----------------------------------------------------------------------------
// aqed_fc_pkg
// Shared definitions for the A-QED FIFO functional-consistency checker slice.
//   - fc_state_t : checker FSM states (IDLE, ORIG, ARMED, DONE)
//   - DEF_DATA_W : default data width of write/read beats
//   - DEF_CNT_W  : default width of index counters and occupancy
// -----------------------------------------------------------------------------
package aqed_fc_pkg;

  localparam int DEF_DATA_W = 16;
  localparam int DEF_CNT_W  = 16;

  // IDLE : waiting for the original mark
  // ORIG : original write tagged, waiting for the duplicate mark
  // ARMED: both writes tagged, waiting for the duplicate to be read back
  // DONE : comparison made; sticky until reset
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ORIG  = 2'd1,
    ARMED = 2'd2,
    DONE  = 2'd3
  } fc_state_t;

endpackage

// File: rtl/aqed_occ_counter.sv
// -----------------------------------------------------------------------------
// aqed_occ_counter
// Up/down occupancy counter for the FIFO driven by the checker, plus a sticky
// underflow flag.
// Ports:
//   clk         in  clock
//   reset       in  synchronous, active-high reset
//   clk_en      in  global enable; state advances only when 1
//   i_inc       in  a write was accepted this cycle
//   i_dec       in  a read beat was accepted this cycle
//   o_occ       out registered occupancy (writes minus reads)
//   o_underflow out sticky; a read beat arrived with occupancy 0
// -----------------------------------------------------------------------------
module aqed_occ_counter
  import aqed_fc_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clk_en,
  input  logic             i_inc,
  input  logic             i_dec,
  output logic [CNT_W-1:0] o_occ,
  output logic             o_underflow
);

  logic [CNT_W-1:0] r_occ;
  logic             r_underflow;
  logic             w_occ_zero;

  assign w_occ_zero = (r_occ == {CNT_W{1'b0}});

  // Occupancy update; a simultaneous write and read cancel each other, and a
  // read with nothing outstanding leaves the count at zero and flags underflow.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_occ       <= {CNT_W{1'b0}};
      r_underflow <= 1'b0;
    end else if (clk_en) begin
      case ({i_inc, i_dec})
        2'b10: begin
          r_occ <= r_occ + {{(CNT_W-1){1'b0}}, 1'b1};
        end
        2'b01: begin
          if (w_occ_zero) begin
            r_underflow <= 1'b1;
          end else begin
            r_occ <= r_occ - {{(CNT_W-1){1'b0}}, 1'b1};
          end
        end
        default: begin
          r_occ <= r_occ;
        end
      endcase
    end
  end

  assign o_occ       = r_occ;
  assign o_underflow = r_underflow;

endmodule

// File: rtl/aqed_fifo_fc_checker.sv
// -----------------------------------------------------------------------------
// aqed_fifo_fc_checker
// Write-side driver and read-side functional-consistency checker around a
// memory core operating as a FIFO. Upstream writes are gated by an occupancy
// credit against the configured depth; the core output is drained whenever
// downstream is not stalled. One write is tagged as the original and a later
// one as the duplicate; when the duplicate is read back its data is compared
// with the data returned for the original.
// Ports:
//   clk, reset     clock and synchronous active-high reset
//   clk_en         global enable; all state advances only when 1
//   depth          configured FIFO depth (static during a run)
//   wr_valid_in    upstream write request
//   wr_data_in     upstream write data
//   mark_orig      tags the write accepted this cycle as the original
//   mark_dup       tags the write accepted this cycle as the duplicate
//   wr_ready       write can be accepted (occupancy < depth)
//   wen_out        write enable to the core
//   wr_data_out    write data to the core (pass-through)
//   rd_stall_in    downstream backpressure
//   ren_out        read enable to the core
//   rd_data_in     core read data
//   rd_valid_in    core read-data valid
//   occupancy      accepted writes minus accepted reads
//   underflow_err  sticky read-with-empty-occupancy flag
//   qed_done       one-cycle pulse when the duplicate read is compared
//   qed_check      comparison result, held after qed_done
// -----------------------------------------------------------------------------
module aqed_fifo_fc_checker
  import aqed_fc_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clk_en,
  input  logic [CNT_W-1:0]  depth,
  input  logic              wr_valid_in,
  input  logic [DATA_W-1:0] wr_data_in,
  input  logic              mark_orig,
  input  logic              mark_dup,
  output logic              wr_ready,
  output logic              wen_out,
  output logic [DATA_W-1:0] wr_data_out,
  input  logic              rd_stall_in,
  output logic              ren_out,
  input  logic [DATA_W-1:0] rd_data_in,
  input  logic              rd_valid_in,
  output logic [CNT_W-1:0]  occupancy,
  output logic              underflow_err,
  output logic              qed_done,
  output logic              qed_check
);

  fc_state_t         r_state;
  fc_state_t         w_state_nxt;

  logic [CNT_W-1:0]  r_wr_idx;
  logic [CNT_W-1:0]  r_rd_idx;
  logic [CNT_W-1:0]  r_orig_idx;
  logic [CNT_W-1:0]  r_dup_idx;
  logic [DATA_W-1:0] r_orig_data;
  logic              r_orig_valid;
  logic              r_ren_d1;
  logic              r_qed_done;
  logic              r_qed_check;

  logic [CNT_W-1:0]  w_occ;
  logic              w_underflow;
  logic              w_wr_ready;
  logic              w_wacc;
  logic              w_ren;
  logic              w_racc;
  logic              w_cap_orig;
  logic              w_cap_dup;
  logic              w_fire;
  logic              w_load_orig;
  logic              w_match;

  // Credit check uses the registered occupancy, so depth=0 never grants.
  assign w_wr_ready = (w_occ < depth);
  assign w_wacc     = clk_en & wr_valid_in & w_wr_ready;
  assign w_ren      = clk_en & ~rd_stall_in;
  // The core returns data one cycle after ren, so a beat only counts when the
  // previous cycle actually issued a read.
  assign w_racc     = clk_en & r_ren_d1 & rd_valid_in;

  aqed_occ_counter #(
    .CNT_W (CNT_W)
  ) u_occ (
    .clk         (clk),
    .reset       (reset),
    .clk_en      (clk_en),
    .i_inc       (w_wacc),
    .i_dec       (w_racc),
    .o_occ       (w_occ),
    .o_underflow (w_underflow)
  );

  // Next-state and capture strobes for the mark/compare FSM.
  always_comb begin
    w_state_nxt = r_state;
    w_cap_orig  = 1'b0;
    w_cap_dup   = 1'b0;
    w_fire      = 1'b0;
    case (r_state)
      IDLE: begin
        // mark_orig wins over a same-cycle mark_dup; the dup mark is dropped.
        if (w_wacc && mark_orig) begin
          w_state_nxt = ORIG;
          w_cap_orig  = 1'b1;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      ORIG: begin
        if (w_wacc && mark_dup) begin
          w_state_nxt = ARMED;
          w_cap_dup   = 1'b1;
        end else begin
          w_state_nxt = ORIG;
        end
      end
      ARMED: begin
        if (w_racc && (r_rd_idx == r_dup_idx)) begin
          w_state_nxt = DONE;
          w_fire      = 1'b1;
        end else begin
          w_state_nxt = ARMED;
        end
      end
      DONE: begin
        w_state_nxt = DONE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // The original's data can come back either before or after the duplicate is
  // marked, so capture is allowed in both ORIG and ARMED, first beat only.
  always_comb begin
    if (((r_state == ORIG) || (r_state == ARMED)) && w_racc &&
        (r_rd_idx == r_orig_idx) && !r_orig_valid) begin
      w_load_orig = 1'b1;
    end else begin
      w_load_orig = 1'b0;
    end
  end

  assign w_match = (rd_data_in == r_orig_data) && r_orig_valid;

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else if (clk_en) begin
      r_state <= w_state_nxt;
    end
  end

  // Write/read index counters; both wrap naturally at 2^CNT_W.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_idx <= {CNT_W{1'b0}};
      r_rd_idx <= {CNT_W{1'b0}};
    end else if (clk_en) begin
      if (w_wacc) begin
        r_wr_idx <= r_wr_idx + {{(CNT_W-1){1'b0}}, 1'b1};
      end
      if (w_racc) begin
        r_rd_idx <= r_rd_idx + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

  // Tagged write indices and captured original data.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_orig_idx   <= {CNT_W{1'b0}};
      r_dup_idx    <= {CNT_W{1'b0}};
      r_orig_data  <= {DATA_W{1'b0}};
      r_orig_valid <= 1'b0;
    end else if (clk_en) begin
      if (w_cap_orig) begin
        r_orig_idx <= r_wr_idx;
      end
      if (w_cap_dup) begin
        r_dup_idx <= r_wr_idx;
      end
      if (w_load_orig) begin
        r_orig_data  <= rd_data_in;
        r_orig_valid <= 1'b1;
      end
    end
  end

  // Delayed read enable marking the cycle in which core data is expected.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ren_d1 <= 1'b0;
    end else if (clk_en) begin
      r_ren_d1 <= w_ren;
    end
  end

  // Compare outputs: done pulses once on ARMED->DONE, check holds its value.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_qed_done  <= 1'b0;
      r_qed_check <= 1'b0;
    end else if (clk_en) begin
      r_qed_done <= w_fire;
      if (w_fire) begin
        r_qed_check <= w_match;
      end
    end
  end

  assign wr_ready      = w_wr_ready;
  assign wen_out       = w_wacc;
  assign wr_data_out   = wr_data_in;
  assign ren_out       = w_ren;
  assign occupancy     = w_occ;
  assign underflow_err = w_underflow;
  assign qed_done      = r_qed_done;
  assign qed_check     = r_qed_check;

endmodule
